// File: rtl/out_post_pkg.sv
// Shared parameters, FSM state type and inner-row vector type for output_post_data_module.
// The relu helper is only used when OUT_POST_RELU_EN is defined.
package out_post_pkg;

  localparam int DATA_W      = 8;
  localparam int ROW_ELEMS   = 34;
  localparam int PAD         = 1;
  localparam int ROWS        = 34;
  localparam int INNER_ELEMS = ROW_ELEMS - 2*PAD;
  localparam int ROW_CNT_W   = $clog2(ROWS);
  localparam int COL_CNT_W   = $clog2(INNER_ELEMS);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  // Element k of the interior row sits at [k]; element 0 is emitted first.
  typedef logic [INNER_ELEMS-1:0][DATA_W-1:0] inner_row_t;

  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/output_post_data_module_serializer.sv
// Parallel-load shift register that turns one interior row into a byte stream
// with valid/ready handshaking and a row-last flag.
module row_serializer
  import out_post_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_load,
  input  logic [INNER_ELEMS*DATA_W-1:0] i_load_row,
  input  logic                          i_data_rdy,
  output logic [DATA_W-1:0]             o_data,
  output logic                          o_data_vld,
  output logic                          o_row_last,
  output logic                          o_last_hs
);

  localparam logic [COL_CNT_W-1:0] COL_LAST = COL_CNT_W'(INNER_ELEMS-1);

  inner_row_t             r_shift;
  logic [COL_CNT_W-1:0]   r_colCnt;
  logic                   r_vld;
  logic                   w_hs;

  assign w_hs       = r_vld && i_data_rdy;
  assign o_row_last = r_vld && (r_colCnt == COL_LAST);
  assign o_last_hs  = w_hs && o_row_last;
  assign o_data     = r_shift[0];
  assign o_data_vld = r_vld;

  // A load only arrives while idle or on the row-last handshake, so it may override the shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= '0;
      r_colCnt <= '0;
      r_vld    <= 1'b0;
    end else if (i_load) begin
      r_shift  <= i_load_row;
      r_colCnt <= '0;
      r_vld    <= 1'b1;
    end else if (w_hs) begin
      r_shift <= {{DATA_W{1'b0}}, r_shift[INNER_ELEMS-1:1]};
      if (o_row_last) begin
        r_colCnt <= '0;
        r_vld    <= 1'b0;
      end else begin
        r_colCnt <= r_colCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_post_data_module.sv
// Back end of the PE datapath: strips padding rows/columns and serialises interior bytes.
// Define OUT_POST_RELU_EN to clamp negative interior bytes to zero at latch time.
module output_post_data_module
  import out_post_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ROW_ELEMS*DATA_W-1:0] i_row_data,
  input  logic                        i_row_vld,
  output logic                        o_row_rdy,
  output logic [DATA_W-1:0]           o_data,
  output logic                        o_data_vld,
  input  logic                        i_data_rdy,
  output logic                        o_row_last,
  output logic                        o_frame_done
);

  localparam logic [ROW_CNT_W-1:0] ROW_LAST       = ROW_CNT_W'(ROWS-1);
  localparam logic [ROW_CNT_W-1:0] ROW_PAD_TOP    = ROW_CNT_W'(PAD);
  localparam logic [ROW_CNT_W-1:0] ROW_PAD_END    = ROW_CNT_W'(ROWS-PAD);
  localparam logic [ROW_CNT_W-1:0] ROW_INNER_LAST = ROW_CNT_W'(ROWS-PAD-1);

  state_t                 r_state;
  logic [ROW_CNT_W-1:0]   r_rowCnt;
  logic [ROW_CNT_W-1:0]   w_inIdx;
  logic                   w_lastHs;
  logic                   w_rowAcc;
  logic                   w_padRow;
  logic                   w_load;
  logic                   w_unusedPad;
  inner_row_t             w_innerRow;

  function automatic logic [ROW_CNT_W-1:0] nextRow(input logic [ROW_CNT_W-1:0] x);
    return (x == ROW_LAST) ? '0 : x + 1'b1;
  endfunction

  // While shifting, r_rowCnt names the row in flight, so an incoming row is the one after it.
  assign o_row_rdy    = (r_state == S_IDLE) || w_lastHs;
  assign w_rowAcc     = i_row_vld && o_row_rdy;
  assign w_inIdx      = (r_state == S_SHIFT) ? nextRow(r_rowCnt) : r_rowCnt;
  assign w_padRow     = (w_inIdx < ROW_PAD_TOP) || (w_inIdx >= ROW_PAD_END);
  assign w_load       = w_rowAcc && !w_padRow;
  assign o_frame_done = w_lastHs && (r_rowCnt == ROW_INNER_LAST);
  assign w_unusedPad  = ^{i_row_data[ROW_ELEMS*DATA_W-1 -: PAD*DATA_W], i_row_data[PAD*DATA_W-1:0]};

  always_comb begin
    w_innerRow = '0;
    for (int k = 0; k < INNER_ELEMS; k++) begin
`ifdef OUT_POST_RELU_EN
      w_innerRow[k] = relu(i_row_data[(ROW_ELEMS-PAD-k)*DATA_W-1 -: DATA_W]);
`else
      w_innerRow[k] = i_row_data[(ROW_ELEMS-PAD-k)*DATA_W-1 -: DATA_W];
`endif
    end
  end

  // A trailing padding row taken on the row-last handshake advances the count twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rowCnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rowAcc) begin
            if (w_padRow) begin
              r_rowCnt <= nextRow(r_rowCnt);
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          if (w_lastHs) begin
            if (w_rowAcc && w_padRow) begin
              r_rowCnt <= nextRow(nextRow(r_rowCnt));
              r_state  <= S_IDLE;
            end else begin
              r_rowCnt <= nextRow(r_rowCnt);
              r_state  <= w_load ? S_SHIFT : S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  row_serializer u_serializer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_row (w_innerRow),
    .i_data_rdy (i_data_rdy),
    .o_data     (o_data),
    .o_data_vld (o_data_vld),
    .o_row_last (o_row_last),
    .o_last_hs  (w_lastHs)
  );

endmodule
